// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous slow clock/strobe in i_clk cycles,
// with optional averaging over 2^AVG_LOG2 periods and a stopped-input timeout.
module clock_period_meter #(
    parameter int INPUT_FREQUENCY = 100000000,
    parameter int COUNT_WIDTH     = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int AVG_LOG2        = 0,
    parameter int TIMEOUT_CYCLES  = INPUT_FREQUENCY
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_meas_clk,
    input  logic                   i_enable,
    output logic [COUNT_WIDTH-1:0] o_period,
    output logic [COUNT_WIDTH-1:0] o_high_time,
    output logic                   o_valid,
    output logic                   o_timeout
);
    localparam int ACC_W  = COUNT_WIDTH + AVG_LOG2;
    localparam int IDX_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [IDX_W-1:0]       IDX_ONE   = IDX_W'(1);
    localparam logic [IDLE_W-1:0]      IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0]      IDLE_SAT  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0]      IDLE_ONE  = IDLE_W'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, TIMEOUT} state_t;

    state_t                   state_reg;
    logic [SYNC_STAGES-1:0]   sync_reg;
    logic                     s_d_reg;
    logic [COUNT_WIDTH-1:0]   per_cnt_reg;
    logic [COUNT_WIDTH-1:0]   hi_cnt_reg;
    logic [IDLE_W-1:0]        idle_cnt_reg;
    logic [IDX_W-1:0]         avg_idx_reg;
    logic [ACC_W-1:0]         acc_p_reg;
    logic [ACC_W-1:0]         acc_h_reg;

    logic                     s;
    logic                     rise;
    logic                     fall;
    logic                     meas_edge;
    logic [COUNT_WIDTH-1:0]   per_inc;
    logic [COUNT_WIDTH-1:0]   hi_inc;
    logic [IDLE_W-1:0]        idle_inc;
    logic [ACC_W-1:0]         acc_p_next;
    logic [ACC_W-1:0]         acc_h_next;

    // Both edges see the same synchronizer + detect latency, so counts stay exact.
    assign s         = sync_reg[SYNC_STAGES-1];
    assign rise      = s & ~s_d_reg;
    assign fall      = ~s & s_d_reg;
    assign meas_edge = rise | fall;

    assign per_inc    = (per_cnt_reg == CNT_MAX) ? per_cnt_reg : per_cnt_reg + CNT_ONE;
    assign hi_inc     = (hi_cnt_reg == CNT_MAX) ? hi_cnt_reg : hi_cnt_reg + CNT_ONE;
    assign idle_inc   = (idle_cnt_reg >= IDLE_SAT) ? idle_cnt_reg : idle_cnt_reg + IDLE_ONE;
    assign acc_p_next = acc_p_reg + ACC_W'(per_cnt_reg);
    assign acc_h_next = acc_h_reg + ACC_W'(hi_cnt_reg);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_meas_clk};
            s_d_reg  <= s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            per_cnt_reg  <= '0;
            hi_cnt_reg   <= '0;
            idle_cnt_reg <= '0;
            avg_idx_reg  <= '0;
            acc_p_reg    <= '0;
            acc_h_reg    <= '0;
            o_period     <= '0;
            o_high_time  <= '0;
            o_valid      <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (!i_enable) begin
                // Partial measurement is dropped; reported values are kept.
                state_reg    <= IDLE;
                per_cnt_reg  <= '0;
                hi_cnt_reg   <= '0;
                idle_cnt_reg <= '0;
                o_timeout    <= 1'b0;
            end else if (state_reg == IDLE) begin
                state_reg    <= ARM;
                per_cnt_reg  <= '0;
                hi_cnt_reg   <= '0;
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= meas_edge ? '0 : idle_inc;
                if (rise) begin
                    per_cnt_reg <= CNT_ONE;
                    hi_cnt_reg  <= CNT_ONE;
                    if (state_reg == MEASURE) begin
                        if (avg_idx_reg == IDX_LAST) begin
                            o_period    <= COUNT_WIDTH'(acc_p_next >> AVG_LOG2);
                            o_high_time <= COUNT_WIDTH'(acc_h_next >> AVG_LOG2);
                            o_valid     <= 1'b1;
                            acc_p_reg   <= '0;
                            acc_h_reg   <= '0;
                            avg_idx_reg <= '0;
                        end else begin
                            acc_p_reg   <= acc_p_next;
                            acc_h_reg   <= acc_h_next;
                            avg_idx_reg <= avg_idx_reg + IDX_ONE;
                        end
                    end else begin
                        state_reg   <= MEASURE;
                        acc_p_reg   <= '0;
                        acc_h_reg   <= '0;
                        avg_idx_reg <= '0;
                        o_timeout   <= 1'b0;
                    end
                end else if (state_reg != TIMEOUT && !fall && idle_cnt_reg >= IDLE_LAST) begin
                    state_reg   <= TIMEOUT;
                    o_timeout   <= 1'b1;
                    o_period    <= '0;
                    o_high_time <= '0;
                end else if (state_reg == MEASURE) begin
                    per_cnt_reg <= per_inc;
                    if (s) begin
                        hi_cnt_reg <= hi_inc;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized bench for clock_period_meter: two instances (no averaging / 4-period averaging)
// checked every cycle against a timestamp-based model, plus literal spot checks.
module tb_clock_period_meter;
    localparam int CW = 16;
    localparam int T  = 1000;
    localparam int S0 = 2;
    localparam int S1 = 3;
    localparam int A0 = 0;
    localparam int A1 = 2;

    localparam int M_OFF  = 0;
    localparam int M_ARM  = 1;
    localparam int M_MEAS = 2;
    localparam int M_TO   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic meas = 1'b0;
    logic enable = 1'b0;
    logic [CW-1:0] period0, high0, period1, high1;
    logic valid0, to0, valid1, to1;

    always #5 clk = ~clk;

    clock_period_meter #(.INPUT_FREQUENCY(T), .COUNT_WIDTH(CW), .SYNC_STAGES(S0),
                         .AVG_LOG2(A0), .TIMEOUT_CYCLES(T)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_meas_clk(meas), .i_enable(enable),
        .o_period(period0), .o_high_time(high0), .o_valid(valid0), .o_timeout(to0));

    clock_period_meter #(.INPUT_FREQUENCY(T), .COUNT_WIDTH(CW), .SYNC_STAGES(S1),
                         .AVG_LOG2(A1), .TIMEOUT_CYCLES(T)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_meas_clk(meas), .i_enable(enable),
        .o_period(period1), .o_high_time(high1), .o_valid(valid1), .o_timeout(to1));

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    // Model: timestamps of detected edges; period = rise-to-rise, high = rise-to-fall.
    typedef struct {
        int mode;
        int last_rise;
        int last_fall;
        int last_act;
        int nper;
        int sum_p;
        int sum_h;
        int e_per;
        int e_hi;
        bit e_val;
        bit e_to;
    } model_t;

    model_t m [2];
    bit hq [$];
    int mcyc = 0;

    task automatic step(input int i, input int A, input int S, input int d);
        bit sv, sdv, rise, fall;
        sv   = hq[S];
        sdv  = hq[S + 1];
        rise = sv & !sdv;
        fall = !sv & sdv;
        m[i].e_val = 1'b0;
        if (!enable) begin
            m[i].mode = M_OFF;
            m[i].e_to = 1'b0;
            return;
        end
        if (m[i].mode == M_OFF) begin
            m[i].mode     = M_ARM;
            m[i].last_act = d;
            return;
        end
        if (rise) begin
            if (m[i].mode == M_MEAS) begin
                m[i].sum_p += d - m[i].last_rise;
                m[i].sum_h += m[i].last_fall - m[i].last_rise;
                m[i].nper++;
                if (m[i].nper == (1 << A)) begin
                    m[i].e_per = m[i].sum_p / (1 << A);
                    m[i].e_hi  = m[i].sum_h / (1 << A);
                    m[i].e_val = 1'b1;
                    m[i].nper  = 0;
                    m[i].sum_p = 0;
                    m[i].sum_h = 0;
                end
            end else begin
                m[i].mode  = M_MEAS;
                m[i].nper  = 0;
                m[i].sum_p = 0;
                m[i].sum_h = 0;
                m[i].e_to  = 1'b0;
            end
            m[i].last_rise = d;
            m[i].last_act  = d;
        end else if (fall) begin
            m[i].last_fall = d;
            m[i].last_act  = d;
        end else if (m[i].mode != M_TO && d - m[i].last_act >= T) begin
            m[i].mode  = M_TO;
            m[i].e_to  = 1'b1;
            m[i].e_per = 0;
            m[i].e_hi  = 0;
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) hq.push_back(1'b0);
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m[0] = '{default: 0};
                m[1] = '{default: 0};
                for (int k = 0; k < 8; k++) hq[k] = 1'b0;
            end else begin
                hq.push_front(meas);
                hq.delete(hq.size() - 1);
                step(0, A0, S0, mcyc);
                step(1, A1, S1, mcyc);
            end
            mcyc++;
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_period0", int'(period0), 0);
                chk("rst_high0", int'(high0), 0);
                chk("rst_valid0", int'(valid0), 0);
                chk("rst_timeout0", int'(to0), 0);
                chk("rst_period1", int'(period1), 0);
                chk("rst_high1", int'(high1), 0);
                chk("rst_valid1", int'(valid1), 0);
                chk("rst_timeout1", int'(to1), 0);
            end else begin
                chk("period0", int'(period0), m[0].e_per);
                chk("high0", int'(high0), m[0].e_hi);
                chk("valid0", int'(valid0), int'(m[0].e_val));
                chk("timeout0", int'(to0), int'(m[0].e_to));
                chk("period1", int'(period1), m[1].e_per);
                chk("high1", int'(high1), m[1].e_hi);
                chk("valid1", int'(valid1), int'(m[1].e_val));
                chk("timeout1", int'(to1), int'(m[1].e_to));
                if (valid0) $display("t=%0t dut0 valid period=%0d high=%0d", $time, period0, high0);
                if (valid1) $display("t=%0t dut1 valid period=%0d high=%0d", $time, period1, high1);
            end
        end
    end

    // One input period; enable is low for cycles [drop_at, drop_at+drop_len).
    task automatic run_period(input int hi, input int lo, input int drop_at, input int drop_len);
        for (int c = 0; c < hi + lo; c++) begin
            @(negedge clk);
            meas   = (c < hi);
            enable = !(drop_len > 0 && c >= drop_at && c < drop_at + drop_len);
        end
    endtask

    task automatic literal4(input string tag, input int p0, input int h0, input int p1, input int h1);
        chk({tag, "_period0"}, int'(period0), p0);
        chk({tag, "_high0"}, int'(high0), h0);
        chk({tag, "_period1"}, int'(period1), p1);
        chk({tag, "_high1"}, int'(high1), h1);
    endtask

    initial begin
        int t0, t1;
        int hi, lo;
        repeat (3) @(negedge clk);
        literal4("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // 50/50 toggle
        repeat (6) run_period(50, 50, 0, 0);
        literal4("sq50", 100, 50, 100, 50);
        chk("model_sq50", m[0].e_per, 100);

        // 30 high / 70 low
        repeat (5) run_period(30, 70, 0, 0);
        chk("duty30_period0", int'(period0), 100);
        chk("duty30_high0", int'(high0), 30);

        // Alternating 99/101 with 40 high: dut1 averages to 100/40
        for (int k = 0; k < 12; k++) run_period(40, (k % 2 == 0) ? 59 : 61, 0, 0);
        literal4("alt", 99, 40, 100, 40);
        chk("model_alt1", m[1].e_per, 100);

        // Enable dropped mid-period: values hold, no valid
        repeat (9) run_period(50, 50, 0, 0);
        run_period(50, 50, 20, 200);
        literal4("drop", 100, 50, 100, 50);
        chk("drop_timeout0", int'(to0), 0);
        repeat (3) run_period(50, 50, 0, 0);

        // Stop input: timeout exactly T cycles after the last edge's own output timing
        repeat (50) begin @(negedge clk); meas = 1'b1; end
        @(negedge clk);
        meas = 1'b0;
        t0 = 0;
        t1 = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (to0 && t0 == 0) t0 = k;
            if (to1 && t1 == 0) t1 = k;
        end
        chk("timeout_latency0", t0, T + S0 + 1);
        chk("timeout_latency1", t1, T + S1 + 1);
        literal4("timeout", 0, 0, 0, 0);
        repeat (3) run_period(50, 50, 0, 0);

        // Asynchronous reset in the middle of a high phase
        repeat (2) run_period(50, 50, 0, 0);
        repeat (20) begin @(negedge clk); meas = 1'b1; end
        #3 rst_n = 1'b0;
        #1;
        literal4("async_rst", 0, 0, 0, 0);
        chk("async_rst_valid0", int'(valid0), 0);
        repeat (3) begin @(negedge clk); meas = 1'b0; end
        rst_n = 1'b1;
        repeat (6) run_period(50, 50, 0, 0);

        // Randomized periods, duty and occasional enable drops
        for (int r = 0; r < 40; r++) begin
            hi = int'($urandom_range(2, 80));
            lo = int'($urandom_range(2, 80));
            if ($urandom_range(0, 7) == 0)
                run_period(hi, lo, int'($urandom_range(0, hi + lo - 1)), int'($urandom_range(1, 30)));
            else
                run_period(hi, lo, 0, 0);
        end
        repeat (4) run_period(50, 50, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
